// File: rtl/prim_fifo_unpack.sv
// Wide-to-narrow unpacker for a FIFO read port. It pops one word and emits it
// LSB chunk first, flagging the final chunk of each word.
`timescale 1ns/1ps
module prim_fifo_unpack #(
  parameter int unsigned InW               = 32,
  parameter int unsigned OutW              = 8,
  parameter bit          OutputZeroIfEmpty = 1'b1,
  localparam int unsigned Ratio            = InW / OutW,
  localparam int unsigned CntW             = (Ratio > 1) ? $clog2(Ratio) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [InW-1:0]  in_data_i,
  input  logic [CntW-1:0] in_cnt_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [OutW-1:0] out_data_o,
  output logic            out_last_o,
  output logic            busy_o
);

  if (((InW % OutW) != 0) || (Ratio < 2)) begin : gen_bad_params
    $error("prim_fifo_unpack: InW must be a multiple of OutW with InW/OutW >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CntW-1:0] MaxCnt = CntW'(Ratio - 1);

  state_t          state_reg;
  logic [InW-1:0]  hold_reg;
  logic [CntW-1:0] idx_reg;
  logic [CntW-1:0] rem_reg;

  logic            shifting;
  logic            last_chunk;
  logic            xfer;
  logic            accept;
  logic [CntW-1:0] cnt_sat;
  logic [OutW-1:0] chunk;
  logic [OutW-1:0] chunks [Ratio];

  // Chunk lanes of the holding register; idx selects the one on the output.
  for (genvar gi = 0; gi < Ratio; gi++) begin : gen_chunks
    assign chunks[gi] = hold_reg[gi*OutW +: OutW];
  end

  assign chunk      = chunks[idx_reg];
  assign shifting   = (state_reg == SHIFT);
  assign last_chunk = shifting & (rem_reg == '0);
  assign xfer       = shifting & out_ready_i;

  // Ready also opens when the last chunk leaves, so words stream with no bubble.
  assign in_ready_o = ~clr_i & (~shifting | (xfer & last_chunk));
  assign accept     = in_valid_i & in_ready_o;

  // Only bites when Ratio is not a power of two and the count field overshoots.
  assign cnt_sat    = (in_cnt_i > MaxCnt) ? MaxCnt : in_cnt_i;

  assign out_valid_o = shifting;
  assign out_last_o  = last_chunk;
  assign out_data_o  = (OutputZeroIfEmpty && !shifting) ? '0 : chunk;
  assign busy_o      = shifting;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      idx_reg   <= '0;
      rem_reg   <= '0;
    end else if (accept) begin
      // Reached from IDLE, or from SHIFT only as the last chunk transfers.
      state_reg <= SHIFT;
      hold_reg  <= in_data_i;
      idx_reg   <= '0;
      rem_reg   <= cnt_sat;
    end else if (xfer) begin
      if (rem_reg != '0) begin
        idx_reg <= idx_reg + CntW'(1);
        rem_reg <= rem_reg - CntW'(1);
      end else begin
        state_reg <= IDLE;
        idx_reg   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prim_fifo_unpack.sv
// Bench for prim_fifo_unpack: per-cycle vector table plus a chunk scoreboard,
// followed by a full-rate single-chunk stream.
`timescale 1ns/1ps
module tb_prim_fifo_unpack;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clr_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [1:0]  in_cnt_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  out_data_o;
  logic        out_last_o;
  logic        busy_o;

  prim_fifo_unpack #(
    .InW(32),
    .OutW(8),
    .OutputZeroIfEmpty(1'b1)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(clr_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i(in_data_i),
    .in_cnt_i(in_cnt_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o(out_data_o),
    .out_last_o(out_last_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [1:0]  c;
    logic        rdy;
    logic        clr;
    logic        rst;
    logic        e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic        e_ol;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } chunk_t;

  vec_t   vecs[$];
  chunk_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     xfers  = 0;

  function automatic void add(input logic v, input logic [31:0] d, input logic [1:0] c,
                              input logic rdy, input logic clr, input logic rst,
                              input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                              input logic e_ol, input logic e_busy);
    vec_t r;
    r = '{v, d, c, rdy, clr, rst, e_ir, e_ov, e_od, e_ol, e_busy};
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // Called at the negedge: pop a transferred chunk, flush on clr/rst, then
  // queue the chunks of any word accepted this cycle.
  task automatic sb_cycle(input logic flush, input int row);
    chunk_t e;
    if (out_valid_o && out_ready_i) begin
      xfers++;
      if (sb.size() == 0) begin
        check("sb_unexpected_chunk", row, {24'h0, out_data_o}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_data", row, {24'h0, out_data_o}, {24'h0, e.d});
        check("sb_last", row, {31'h0, out_last_o}, {31'h0, e.last});
      end
    end
    if (flush) sb.delete();
    if (!flush && in_valid_i && in_ready_o) begin
      for (int i = 0; i <= int'(in_cnt_i); i++) begin
        e.d    = in_data_i[i*8 +: 8];
        e.last = (i == int'(in_cnt_i));
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // Test 1: reset state then a full word.
    add(0, 32'h0,        0, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    add(1, 32'hDDCCBBAA, 3, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'hAA, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'hBB, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'hCC, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  1, 1, 8'hDD, 1, 1);
    add(0, 32'h0,        0, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    // Test 2: partial word, two chunks.
    add(1, 32'h44332211, 1, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'h11, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  1, 1, 8'h22, 1, 1);
    add(0, 32'h0,        0, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    // Test 3: back-to-back words.
    add(1, 32'h03020100, 3, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    add(1, 32'h07060504, 3, 1, 0, 0,  0, 1, 8'h00, 0, 1);
    add(1, 32'h07060504, 3, 1, 0, 0,  0, 1, 8'h01, 0, 1);
    add(1, 32'h07060504, 3, 1, 0, 0,  0, 1, 8'h02, 0, 1);
    add(1, 32'h07060504, 3, 1, 0, 0,  1, 1, 8'h03, 1, 1);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'h04, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'h05, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'h06, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  1, 1, 8'h07, 1, 1);
    add(0, 32'h0,        0, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    // Test 4: backpressure on 0xBB for five cycles.
    add(1, 32'hDDCCBBAA, 3, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'hAA, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 32'h0, 0, 0, 0, 0,  0, 1, 8'hBB, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'hBB, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'hCC, 0, 1);
    add(0, 32'h0,        0, 1, 0, 0,  1, 1, 8'hDD, 1, 1);
    add(0, 32'h0,        0, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    // Test 5: clear at idx 2, then the same with reset.
    for (int k = 0; k < 2; k++) begin
      add(1, 32'h13121110, 3, 1, 0, 0,  1, 0, 8'h00, 0, 0);
      add(1, 32'h23222120, 3, 1, 0, 0,  0, 1, 8'h10, 0, 1);
      add(1, 32'h23222120, 3, 1, 0, 0,  0, 1, 8'h11, 0, 1);
      add(1, 32'h23222120, 3, 1, (k == 0), (k == 1),  0, 1, 8'h12, 0, 1);
      add(1, 32'h23222120, 3, 1, 0, 0,  1, 0, 8'h00, 0, 0);
      add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'h20, 0, 1);
      add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'h21, 0, 1);
      add(0, 32'h0,        0, 1, 0, 0,  0, 1, 8'h22, 0, 1);
      add(0, 32'h0,        0, 1, 0, 0,  1, 1, 8'h23, 1, 1);
      add(0, 32'h0,        0, 1, 0, 0,  1, 0, 8'h00, 0, 0);
    end

    rst_i = 1'b1; clr_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
    in_cnt_i = '0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      in_valid_i = vecs[r].v;  in_data_i = vecs[r].d;  in_cnt_i = vecs[r].c;
      out_ready_i = vecs[r].rdy; clr_i = vecs[r].clr;  rst_i = vecs[r].rst;
      @(negedge clk_i);
      check("in_ready",  r, {31'h0, in_ready_o},  {31'h0, vecs[r].e_ir});
      check("out_valid", r, {31'h0, out_valid_o}, {31'h0, vecs[r].e_ov});
      check("out_data",  r, {24'h0, out_data_o},  {24'h0, vecs[r].e_od});
      check("out_last",  r, {31'h0, out_last_o},  {31'h0, vecs[r].e_ol});
      check("busy",      r, {31'h0, busy_o},      {31'h0, vecs[r].e_busy});
      sb_cycle(vecs[r].clr | vecs[r].rst, r);
      @(posedge clk_i);
      #1;
    end
    clr_i = 1'b0; rst_i = 1'b0;
    check("sb_drained_table", 0, sb.size(), 0);

    // Test 6: single-chunk words at one word per cycle.
    xfers = 0;
    out_ready_i = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      in_valid_i = (k < 16);
      in_data_i  = $urandom;
      in_cnt_i   = 2'd0;
      @(negedge clk_i);
      check("fr_in_ready",  1000 + k, {31'h0, in_ready_o},  32'h1);
      check("fr_out_valid", 1000 + k, {31'h0, out_valid_o}, (k > 0) ? 32'h1 : 32'h0);
      if (k > 0) check("fr_out_last", 1000 + k, {31'h0, out_last_o}, 32'h1);
      sb_cycle(1'b0, 1000 + k);
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check("fr_idle_busy", 1017, {31'h0, busy_o}, 32'h0);
    check("fr_throughput", 1017, xfers, 16);
    check("sb_drained_stream", 1017, sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
